// File: rtl/regex_cpu_memory_arbiter.sv
// rtl/regex_cpu_memory_arbiter.sv - round-robin share of one instruction RAM read port
//
// Purpose: arbitrates the fetch ports of N_CPU regex CPUs onto a single
// synchronous RAM read port. Issues at most one read per cycle, tracks reads in
// flight through the fixed RAM latency, and returns each word to its requester
// as a one-cycle ready pulse.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   cpu_memory_valid    per-CPU fetch request, held until served
//   cpu_memory_addr     per-CPU fetch address, slot i at [i*W +: W]
//   cpu_memory_ready    per-CPU one-cycle response pulse (at most one high)
//   cpu_memory_data     returned word, broadcast, qualified by ready
//   ram_en, ram_addr    RAM read request
//   ram_data            RAM read data, RAM_LATENCY cycles after ram_en
//   outstanding         per-CPU granted-but-not-yet-transferred flag
//   busy                any CPU outstanding
module regex_cpu_memory_arbiter #(
  parameter int CPU_ID_BITS       = 2,
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11,
  parameter int RAM_LATENCY       = 1,
  localparam int N_CPU            = 2 ** CPU_ID_BITS
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_CPU-1:0]                     cpu_memory_valid,
  input  logic [N_CPU*MEMORY_ADDR_WIDTH-1:0]   cpu_memory_addr,
  output logic [N_CPU-1:0]                     cpu_memory_ready,
  output logic [MEMORY_WIDTH-1:0]              cpu_memory_data,
  output logic                                 ram_en,
  output logic [MEMORY_ADDR_WIDTH-1:0]         ram_addr,
  input  logic [MEMORY_WIDTH-1:0]              ram_data,
  output logic [N_CPU-1:0]                     outstanding,
  output logic                                 busy
);

  localparam int AW = MEMORY_ADDR_WIDTH;

  logic [CPU_ID_BITS-1:0]                  last_grant_q, last_grant_d;
  logic [N_CPU-1:0]                        outstanding_q, outstanding_d;
  logic                                    ram_en_q, ram_en_d;
  logic [AW-1:0]                           ram_addr_q, ram_addr_d;
  logic [N_CPU-1:0]                        ready_q, ready_d;
  logic [MEMORY_WIDTH-1:0]                 data_q, data_d;
  // Stage 0 is written on the grant edge; stage RAM_LATENCY lines up with ram_data.
  logic [RAM_LATENCY:0]                    pipe_valid_q, pipe_valid_d;
  logic [RAM_LATENCY:0][CPU_ID_BITS-1:0]   pipe_id_q, pipe_id_d;

  logic [N_CPU-1:0]       eligible;
  logic                   grant_any;
  logic [CPU_ID_BITS-1:0] winner;
  logic [CPU_ID_BITS-1:0] idx;

  // Round-robin search from last_grant+1; the id arithmetic wraps naturally,
  // so the final candidate (k == N_CPU) is last_grant itself.
  always_comb begin
    eligible  = cpu_memory_valid & ~outstanding_q;
    grant_any = 1'b0;
    winner    = last_grant_q;
    idx       = '0;
    for (int k = 1; k <= N_CPU; k++) begin
      idx = last_grant_q + CPU_ID_BITS'(k);
      if (!grant_any && eligible[idx]) begin
        grant_any = 1'b1;
        winner    = idx;
      end
    end
  end

  always_comb begin
    last_grant_d  = last_grant_q;
    // A ready pulse now means the transfer happens on this edge.
    outstanding_d = outstanding_q & ~ready_q;
    ram_en_d      = grant_any;
    ram_addr_d    = ram_addr_q;
    pipe_valid_d  = {pipe_valid_q[RAM_LATENCY-1:0], grant_any};
    pipe_id_d     = {pipe_id_q[RAM_LATENCY-1:0], winner};
    ready_d       = '0;
    data_d        = data_q;

    if (grant_any) begin
      last_grant_d          = winner;
      outstanding_d[winner] = 1'b1;
      ram_addr_d            = cpu_memory_addr[int'(winner)*AW +: AW];
    end

    if (pipe_valid_q[RAM_LATENCY]) begin
      ready_d[pipe_id_q[RAM_LATENCY]] = 1'b1;
      data_d                          = ram_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q  <= '1;
      outstanding_q <= '0;
      ram_en_q      <= 1'b0;
      ram_addr_q    <= '0;
      ready_q       <= '0;
      data_q        <= '0;
      pipe_valid_q  <= '0;
      pipe_id_q     <= '0;
    end else begin
      last_grant_q  <= last_grant_d;
      outstanding_q <= outstanding_d;
      ram_en_q      <= ram_en_d;
      ram_addr_q    <= ram_addr_d;
      ready_q       <= ready_d;
      data_q        <= data_d;
      pipe_valid_q  <= pipe_valid_d;
      pipe_id_q     <= pipe_id_d;
    end
  end

  assign cpu_memory_ready = ready_q;
  assign cpu_memory_data  = data_q;
  assign ram_en           = ram_en_q;
  assign ram_addr         = ram_addr_q;
  assign outstanding      = outstanding_q;
  assign busy             = |outstanding_q;

endmodule

// File: tb/tb_regex_cpu_memory_arbiter.sv
// tb/tb_regex_cpu_memory_arbiter.sv - bench for regex_cpu_memory_arbiter
//
// Instance a uses RAM_LATENCY=1 and is compared against a queue-based model;
// instance b uses RAM_LATENCY=3 and is checked with a per-CPU scoreboard.
module tb_regex_cpu_memory_arbiter;

  localparam int N  = 4;
  localparam int AW = 11;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mem [0:2047];

  logic [N-1:0]    a_valid, a_ready, a_out;
  logic [N*AW-1:0] a_addr;
  logic [DW-1:0]   a_data, a_ram_data;
  logic            a_ram_en, a_busy;
  logic [AW-1:0]   a_ram_addr;

  logic [N-1:0]    b_valid, b_ready, b_out;
  logic [N*AW-1:0] b_addr;
  logic [DW-1:0]   b_data, b_ram_data;
  logic            b_ram_en, b_busy;
  logic [AW-1:0]   b_ram_addr;

  regex_cpu_memory_arbiter #(.CPU_ID_BITS(2), .MEMORY_WIDTH(DW), .MEMORY_ADDR_WIDTH(AW), .RAM_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst),
    .cpu_memory_valid(a_valid), .cpu_memory_addr(a_addr),
    .cpu_memory_ready(a_ready), .cpu_memory_data(a_data),
    .ram_en(a_ram_en), .ram_addr(a_ram_addr), .ram_data(a_ram_data),
    .outstanding(a_out), .busy(a_busy)
  );

  regex_cpu_memory_arbiter #(.CPU_ID_BITS(2), .MEMORY_WIDTH(DW), .MEMORY_ADDR_WIDTH(AW), .RAM_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst),
    .cpu_memory_valid(b_valid), .cpu_memory_addr(b_addr),
    .cpu_memory_ready(b_ready), .cpu_memory_data(b_data),
    .ram_en(b_ram_en), .ram_addr(b_ram_addr), .ram_data(b_ram_data),
    .outstanding(b_out), .busy(b_busy)
  );

  // RAM models: data valid only in its slot, noise otherwise.
  always @(posedge clk) a_ram_data <= a_ram_en ? mem[a_ram_addr] : DW'($urandom);

  logic          b_p0_en = 1'b0, b_p1_en = 1'b0;
  logic [AW-1:0] b_p0_addr = '0, b_p1_addr = '0;
  always @(posedge clk) begin
    b_p0_en    <= b_ram_en;
    b_p0_addr  <= b_ram_addr;
    b_p1_en    <= b_p0_en;
    b_p1_addr  <= b_p0_addr;
    b_ram_data <= b_p1_en ? mem[b_p1_addr] : DW'($urandom);
  end

  // Reference model for instance a: grants by rotating priority, responses
  // scheduled in a queue by due cycle, data taken straight from mem.
  typedef struct { int due; int id; logic [AW-1:0] addr; } pend_t;
  pend_t         pend[$];
  int            cyc, m_last, mw;
  logic [N-1:0]  m_out, m_ready, mel;
  logic          m_en;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc = 0; m_last = N - 1; m_out = '0; m_ready = '0;
      m_en = 1'b0; m_addr = '0; m_data = '0; pend.delete();
    end else begin
      cyc++;
      mel   = a_valid & ~m_out;
      m_out = m_out & ~m_ready;
      mw    = -1;
      for (int k = 1; k <= N; k++)
        if (mw < 0 && mel[(m_last + k) % N]) mw = (m_last + k) % N;
      m_en    = (mw >= 0);
      m_ready = '0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        m_ready[pend[0].id] = 1'b1;
        m_data = mem[pend[0].addr];
        void'(pend.pop_front());
      end
      if (mw >= 0) begin
        m_last    = mw;
        m_out[mw] = 1'b1;
        m_addr    = a_addr[mw*AW +: AW];
        pend.push_back('{cyc + 2, mw, m_addr});
      end
    end
  end

  task automatic drive_idle();
    a_valid = '0; a_addr = '0; b_valid = '0; b_addr = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; drive_idle();
    @(negedge clk); @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [DW+AW+2*N+1:0] snap;
    @(negedge clk);
    snap = {a_ram_en, a_ram_addr, a_ready, a_data, a_out, a_busy};
    checks++; if (snap !== '0) begin failures++; $display("FAIL reset_a got=%h exp=0", snap); end
    snap = {b_ram_en, b_ram_addr, b_ready, b_data, b_out, b_busy};
    checks++; if (snap !== '0) begin failures++; $display("FAIL reset_b got=%h exp=0", snap); end
    rst = 1'b0; a_valid = 4'b0001; a_addr[0 +: AW] = 11'h033;
    @(negedge clk);
    checks++; if ({a_ram_en, a_out} !== 5'b1_0001) begin failures++; $display("FAIL reset_pre_inflight got=%b exp=10001", {a_ram_en, a_out}); end
    a_valid = '0;
    @(posedge clk); #2; rst = 1'b1; #1;
    snap = {a_ram_en, a_ram_addr, a_ready, a_data, a_out, a_busy};
    checks++; if (snap !== '0) begin failures++; $display("FAIL reset_async got=%h exp=0", snap); end
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if ({a_ready, a_out} !== '0) begin failures++; $display("FAIL reset_no_ready k=%0d ready=%b out=%b exp=0", k, a_ready, a_out); end
    end
  endtask

  task automatic test_single_fetch();
    do_reset();
    a_valid[2] = 1'b1; a_addr[2*AW +: AW] = 11'h05A;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (a_ram_en !== (k == 0)) begin failures++; $display("FAIL single_ram_en k=%0d got=%b exp=%b", k, a_ram_en, (k == 0)); end
      checks++; if (a_ready !== ((k == 2) ? 4'b0100 : 4'b0000)) begin failures++; $display("FAIL single_ready k=%0d got=%b", k, a_ready); end
      checks++; if (a_out !== ((k < 3) ? 4'b0100 : 4'b0000)) begin failures++; $display("FAIL single_outstanding k=%0d got=%b", k, a_out); end
      if (k == 0) begin
        checks++; if (a_ram_addr !== 11'h05A) begin failures++; $display("FAIL single_ram_addr got=%h exp=05a", a_ram_addr); end
      end
      if (k == 2) begin
        checks++; if (a_data !== 16'hA5C3) begin failures++; $display("FAIL single_data got=%h exp=a5c3", a_data); end
        a_valid = '0;
      end
    end
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL single_busy got=%b exp=0", a_busy); end
  endtask

  task automatic test_round_robin();
    @(negedge clk); rst = 1'b1; drive_idle();
    a_valid = 4'hF;
    for (int i = 0; i < N; i++) a_addr[i*AW +: AW] = AW'(16 * (i + 1));
    @(negedge clk); @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k < 4) begin
        checks++; if ({a_ram_en, a_ram_addr} !== {1'b1, AW'(16 * (k + 1))}) begin failures++; $display("FAIL rr_grant k=%0d en=%b addr=%h exp addr=%h", k, a_ram_en, a_ram_addr, 16 * (k + 1)); end
      end else begin
        checks++; if (a_ram_en !== 1'b0) begin failures++; $display("FAIL rr_idle k=%0d en=%b exp=0", k, a_ram_en); end
      end
      if (k >= 2) begin
        checks++; if (a_ready !== (N'(1) << (k - 2))) begin failures++; $display("FAIL rr_ready k=%0d got=%b", k, a_ready); end
        checks++; if (a_data !== mem[AW'(16 * (k - 1))]) begin failures++; $display("FAIL rr_data k=%0d got=%h exp=%h", k, a_data, mem[AW'(16 * (k - 1))]); end
      end
      if (k == 3) a_valid = '0;
    end
  endtask

  task automatic test_back_to_back();
    int en_k[$];
    logic [AW-1:0] en_a[$];
    int reads100;
    reads100 = 0;
    do_reset();
    a_valid[1] = 1'b1; a_addr[AW +: AW] = 11'h100;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (a_ram_en) begin
        en_k.push_back(k); en_a.push_back(a_ram_addr);
        if (a_ram_addr == 11'h100) reads100++;
      end
      if (k == 3) a_addr[AW +: AW] = 11'h101;
      if (k == 4) a_valid = '0;
    end
    checks++;
    if (en_k.size() != 2) begin
      failures++; $display("FAIL b2b_count got=%0d exp=2", en_k.size());
    end else begin
      checks++; if (en_k[1] - en_k[0] != 4) begin failures++; $display("FAIL b2b_spacing got=%0d exp=4", en_k[1] - en_k[0]); end
      checks++; if (en_a[1] !== 11'h101) begin failures++; $display("FAIL b2b_addr got=%h exp=101", en_a[1]); end
    end
    checks++; if (reads100 != 1) begin failures++; $display("FAIL b2b_dup got=%0d exp=1", reads100); end
  endtask

  task automatic test_fairness();
    int g[$];
    do_reset();
    a_valid = 4'b0001; a_addr[0 +: AW] = 11'h200;
    @(negedge clk); a_valid = '0;
    repeat (4) @(negedge clk);
    a_valid = 4'b1001; a_addr[3*AW +: AW] = 11'h203;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (a_ram_en) g.push_back((a_ram_addr == 11'h203) ? 3 : 0);
    end
    a_valid = '0;
    checks++;
    if (g.size() < 6) begin
      failures++; $display("FAIL fair_count got=%0d exp>=6", g.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++; if (g[i] != ((i % 2 == 0) ? 3 : 0)) begin failures++; $display("FAIL fair_order i=%0d got=%0d exp=%0d", i, g[i], (i % 2 == 0) ? 3 : 0); end
      end
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      checks++; if (a_ram_en !== m_en) begin failures++; $display("FAIL rnd_ram_en c=%0d got=%b exp=%b", c, a_ram_en, m_en); end
      checks++; if (a_ram_addr !== m_addr) begin failures++; $display("FAIL rnd_ram_addr c=%0d got=%h exp=%h", c, a_ram_addr, m_addr); end
      checks++; if (a_ready !== m_ready) begin failures++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, a_ready, m_ready); end
      checks++; if (a_data !== m_data) begin failures++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, a_data, m_data); end
      checks++; if (a_out !== m_out) begin failures++; $display("FAIL rnd_outstanding c=%0d got=%b exp=%b", c, a_out, m_out); end
      checks++; if (a_busy !== (m_out != 0)) begin failures++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, a_busy, (m_out != 0)); end
      checks++; if ($countones(a_ready) > 1) begin failures++; $display("FAIL rnd_onehot c=%0d got=%b", c, a_ready); end
      for (int i = 0; i < N; i++) begin
        if (a_valid[i]) begin
          if (m_out[i] && $urandom_range(3) == 0) a_valid[i] = 1'b0;
        end else if ($urandom_range(1) == 1) begin
          a_valid[i] = 1'b1;
          a_addr[i*AW +: AW] = AW'($urandom);
        end
      end
    end
    a_valid = '0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_latency3();
    logic [N-1:0]  pend_b;
    int            gcyc[N];
    logic [AW-1:0] gaddr[N];
    int            id, served;
    do_reset();
    b_valid[2] = 1'b1; b_addr[2*AW +: AW] = 11'h05A;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      checks++; if (b_ready !== ((k == 4) ? 4'b0100 : 4'b0000)) begin failures++; $display("FAIL lat3_ready k=%0d got=%b", k, b_ready); end
      if (k == 4) begin
        checks++; if (b_data !== 16'hA5C3) begin failures++; $display("FAIL lat3_data got=%h exp=a5c3", b_data); end
        b_valid = '0;
      end
    end
    pend_b = '0; served = 0;
    for (int i = 0; i < N; i++) begin gcyc[i] = 0; gaddr[i] = '0; end
    for (int c = 0; c < 340; c++) begin
      @(negedge clk);
      if (b_ram_en) begin
        id = int'(b_ram_addr[1:0]);
        checks++; if (pend_b[id] || !b_valid[id]) begin failures++; $display("FAIL lat3_grant c=%0d id=%0d pending=%b valid=%b exp pending=0 valid=1", c, id, pend_b[id], b_valid[id]); end
        pend_b[id] = 1'b1; gcyc[id] = c; gaddr[id] = b_ram_addr;
      end
      if (b_ready != '0) begin
        checks++; if ($countones(b_ready) != 1) begin failures++; $display("FAIL lat3_onehot c=%0d got=%b", c, b_ready); end
        id = 0;
        for (int i = 0; i < N; i++) if (b_ready[i]) id = i;
        checks++;
        if (!pend_b[id] || (c - gcyc[id]) != 4 || b_data !== mem[gaddr[id]]) begin
          failures++;
          $display("FAIL lat3_resp c=%0d id=%0d pending=%b lat=%0d data=%h exp lat=4 data=%h", c, id, pend_b[id], c - gcyc[id], b_data, mem[gaddr[id]]);
        end
        pend_b[id] = 1'b0; b_valid[id] = 1'b0; served++;
      end
      if (c < 300) begin
        for (int i = 0; i < N; i++) begin
          if (!b_valid[i] && !pend_b[i] && $urandom_range(1) == 1) begin
            b_valid[i] = 1'b1;
            b_addr[i*AW +: AW] = {9'($urandom), 2'(i)};
          end
        end
      end
    end
    checks++; if (pend_b != '0 || b_valid != '0) begin failures++; $display("FAIL lat3_drain pending=%b valid=%b exp=0", pend_b, b_valid); end
    checks++; if (served < 20) begin failures++; $display("FAIL lat3_served got=%0d exp>=20", served); end
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    for (int i = 0; i < 2048; i++) mem[i] = DW'($urandom);
    mem[11'h05A] = 16'hA5C3;
    repeat (2) @(negedge clk);
    test_reset();
    test_single_fetch();
    test_round_robin();
    test_back_to_back();
    test_fairness();
    test_random();
    test_latency3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regex_cpu_memory_arbiter.md
# regex_cpu_memory_arbiter

Round-robin arbiter that shares one synchronous instruction RAM read port among `N_CPU` `regex_cpu_pipelined` instances. Each CPU's `memory_valid`/`memory_addr`/`memory_ready`/`memory_data` fetch port connects to one requester slot. The block issues at most one RAM read per cycle and tracks in-flight reads through the fixed RAM latency. It routes each returned instruction word back to the CPU that requested it as a one-cycle ready pulse.

## Interface
- `CPU_ID_BITS`, 2: number of requesters `N_CPU = 2**CPU_ID_BITS`.
- `MEMORY_WIDTH`, 16: instruction word width.
- `MEMORY_ADDR_WIDTH`, 11: instruction address width.
- `RAM_LATENCY`, 1: cycles from the `ram_en` cycle to valid `ram_data`; legal range ≥1.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `cpu_memory_valid`  in  N_CPU  per-CPU fetch request; held high until served.
- `cpu_memory_addr`  in  N_CPU*MEMORY_ADDR_WIDTH  per-CPU fetch address; slot i occupies bits [i*W +: W]; stable while its valid is high.
- `cpu_memory_ready`  out  N_CPU  per-CPU one-cycle response pulse; at most one bit high per cycle.
- `cpu_memory_data`  out  MEMORY_WIDTH  returned word, broadcast to all CPUs; meaningful only with a ready bit.
- `ram_en`  out  1  RAM read enable.
- `ram_addr`  out  MEMORY_ADDR_WIDTH  RAM read address.
- `ram_data`  in  MEMORY_WIDTH  RAM read data, valid RAM_LATENCY cycles after the `ram_en` cycle.
- `outstanding`  out  N_CPU  per-CPU bit: request granted, response not yet transferred.
- `busy`  out  1  OR of `outstanding`.

## Operation
- Eligibility: `eligible[i] = cpu_memory_valid[i] & ~outstanding[i]`.
- Grant: on each edge with any eligible bit, select one CPU round-robin.
  - Search starts at `last_grant+1` (mod N_CPU); the first eligible index wins.
  - On that edge: `last_grant <= winner`, `outstanding[winner] <= 1`, `ram_en <= 1`, `ram_addr <= addr[winner]`.
  - The winner id is pushed into the in-flight pipe.
  - With no eligible requester, `ram_en <= 0` and `ram_addr` holds its value.
- In-flight pipe: a shift register of (valid, id), depth RAM_LATENCY+1, advancing every cycle, so it realigns with `ram_data`.
  - When an entry emerges aligned with valid `ram_data`, the next edge registers `cpu_memory_ready[id] <= 1` and `cpu_memory_data <= ram_data`.
  - Otherwise `cpu_memory_ready <= 0`; `cpu_memory_data` holds its value.
- Transfer: occurs on the edge where `cpu_memory_ready[i]` is high. That edge clears `outstanding[i]`.
  - The CPU is eligible again from the following edge.
  - A CPU that keeps valid high back-to-back therefore cannot be re-granted on its transfer edge.
- A CPU dropping valid while outstanding does not cancel the read: the response is still pulsed and `outstanding` clears normally.
- Grant and transfer for different CPUs on the same edge are independent.
- A simultaneous grant and clear for the same CPU cannot occur, because `outstanding` masks eligibility.
- Reset values: `ram_en=0`, `ram_addr=0`, `cpu_memory_ready=0`, `cpu_memory_data=0`, `outstanding=0`, `busy=0`, pipe all invalid, `last_grant=N_CPU-1` (CPU 0 has first priority).
- Reset mid-operation: all in-flight reads are discarded and no ready pulses are produced for them. Returning `ram_data` is ignored.

## Timing
- Request sampled at edge E0 (grant).
- `ram_en`/`ram_addr` are high during cycle E0→E1.
- `ram_data` is valid during E(L)→E(L+1), where L = RAM_LATENCY.
- `cpu_memory_ready`/`data` are high during E(L+1)→E(L+2); transfer occurs at E(L+2).
- Earliest re-grant of the same CPU is E(L+3). For L=1: grant E0, ready during E2→E3, re-grant E4.
- Throughput is one grant per cycle across CPUs, with N_CPU reads in flight at most.
- `busy` and `outstanding` are registered and reflect state after the current edge.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle. All outputs go to 0 immediately without a clock edge. No ready pulse appears afterwards even if a read was in flight.
- **Single fetch, L=1:** CPU2 requests addr 0x05A; RAM returns 0xA5C3.
  - `ram_en=1`, `ram_addr=0x05A` in the cycle after E0.
  - `cpu_memory_ready=4'b0100`, `data=0xA5C3` only in cycle E2→E3.
  - `outstanding[2]` is high from E0 to E3.
- **Round-robin:** all four CPUs hold valid from reset with addrs 0x010/0x020/0x030/0x040.
  - Grants are issued in order 0,1,2,3 on consecutive edges.
  - Ready pulses arrive 0,1,2,3 on consecutive cycles with matching data.
- **Back-to-back same CPU:** CPU1 holds valid continuously (addr 0x100, then 0x101 after its transfer).
  - The second `ram_en` appears exactly 4 edges after the first.
  - No duplicate read of 0x100 occurs.
- **Fairness under contention:** CPUs 0 and 3 request continuously, with `last_grant=0`. Grants alternate 3,0,3,0, and neither CPU waits more than one grant slot.
- **Latency sweep:** repeat the single-fetch case with RAM_LATENCY=3. Ready is high in cycle E4→E5, and the response id matches the requester under interleaved traffic.
